div_restoring_seq: RTL and testbench
====================================

// Module: div_restoring_seq
// PURPOSE
//  Multi-cycle unsigned restoring divider, one quotient bit per clock.
//  Inverse companion to the ALU add/adc/sub datapath: it reuses the same
//  borrow-based subtract step, iterated WIDTH times.
//  Sits beside the ALU behind a start/busy/done handshake; results are
//  registered and hold until the next operation completes.
// PARAMETERS
//  WIDTH   32   operand, quotient and remainder width in bits (>= 2)
// PORTS
//  clk           in   1      rising-edge clock
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      request; sampled only when busy=0
//  dividend      in   WIDTH  numerator; captured on the accepted start edge
//  divisor       in   WIDTH  denominator; captured on the accepted start edge
//  busy          out  1      high while an operation is in progress
//  done          out  1      one-cycle pulse; results valid from this cycle on
//  quotient      out  WIDTH  registered quotient
//  remainder     out  WIDTH  registered remainder
//  div_by_zero   out  1      registered; set with done when divisor == 0
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, quotient=0,
//   remainder=0, div_by_zero=0, iteration counter=0. This holds regardless
//   of state; an operation in flight is abandoned with no done pulse.
//  States: IDLE, CALC.
//  IDLE: start=1 at edge k -> capture operands.
//   - divisor!=0: go to CALC. busy=1 from edge k. Counter=WIDTH.
//     Working quotient reg = dividend. Partial remainder R (WIDTH+1 bits) = 0.
//   - divisor==0: stay in IDLE and pulse done at edge k+1, with
//     quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
//     busy is never asserted on this path.
//  CALC, each edge:
//   - S = {R[WIDTH-1:0], Q[WIDTH-1]}. T = S - {1'b0,divisor}, computed
//     WIDTH+1 bits wide.
//   - T[WIDTH]==0 (no borrow): R=T and shift 1 into Q's LSB.
//   - Otherwise: R=S and shift 0 into Q's LSB.
//   - Counter decrements by 1.
//  After the iteration where the counter reaches 0, which is edge k+WIDTH:
//   - quotient=Q and remainder=R[WIDTH-1:0] are updated.
//   - div_by_zero=0, done=1 for exactly one cycle, busy=0, state=IDLE.
//  Latency: done is visible WIDTH cycles after the accepted start edge.
//   The divide-by-zero path takes 1 cycle.
//  start while busy=1 is ignored; the operands are not re-captured.
//  start is accepted in the same cycle done=1, since busy=0 then. This gives
//   back-to-back operation with no idle cycle.
//  quotient, remainder and div_by_zero change only on a done edge. They hold
//   their previous values throughout a new operation.
//  Post-conditions:
//   - normal path: dividend == quotient*divisor + remainder and remainder < divisor.
//   - divide-by-zero path: remainder == dividend.
//  Counter width is $clog2(WIDTH+1). All arithmetic is unsigned with no
//   signed interpretation.
// TESTING
//  T1: 100/7 -> after 32 cycles done=1: quotient=14, remainder=2,
//      div_by_zero=0. busy is high for exactly 32 cycles.
//  T2: 82347156/9483 -> quotient=8683, remainder=6267. Then swap the
//      operands, 9483/82347156 -> quotient=0, remainder=9483.
//  T3: 5/0 -> done one cycle after start, quotient=32'hFFFFFFFF,
//      remainder=5, div_by_zero=1, busy stays 0.
//  T4: 32'hFFFFFFFF/1 -> quotient=32'hFFFFFFFF, remainder=0.
//      32'hFFFFFFFF/32'hFFFFFFFF -> quotient=1, remainder=0.
//  T5: Start 100/7, pulse start with 50/5 at cycle 10 -> the second start is
//      ignored and the result is 14 r 2. Then assert start with 50/5 on the
//      done cycle -> accepted, and 32 cycles later quotient=10, remainder=0.
//  T6: Drop rst_n at cycle 15 of a division -> outputs clear at once with no
//      done pulse. After rst_n rises, 9/3 completes normally with
//      quotient=3, remainder=0.

Source files
------------

// File: rtl/div_restoring_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock behind a
// start/busy/done handshake, with registered results that hold between operations.
module div_restoring_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_work;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] div_reg;
  logic             dbz_pend;
  logic             accept;
  logic             zero_div;
  logic             last_iter;
  logic [WIDTH-1:0] r_step;
  logic             q_bit;

  // One restoring step. The partial remainder is always below the divisor,
  // so its top bit (bit WIDTH of the WIDTH+1-bit form) is zero and is not stored.
  function automatic logic [WIDTH:0] sub_step(input logic [WIDTH-1:0] r,
                                              input logic             msb,
                                              input logic [WIDTH-1:0] d);
    logic [WIDTH:0] t;
    t = {r, msb} - {1'b0, d};
    return t[WIDTH] ? {r[WIDTH-2:0], msb, 1'b0} : {t[WIDTH-1:0], 1'b1};
  endfunction

  assign {r_step, q_bit} = sub_step(r_work, q_work[WIDTH-1], div_reg);

  // A pending divide-by-zero result blocks a new start for its single cycle.
  assign accept    = (state == IDLE) && start && !dbz_pend;
  assign zero_div  = (divisor == '0);
  assign last_iter = (cnt == CW'(1));
  assign busy      = (state == CALC);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !zero_div) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      done        <= 1'b0;
      dbz_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (accept) begin
        cnt      <= zero_div ? '0 : CW'(WIDTH);
        dbz_pend <= zero_div;
      end
      if (dbz_pend) begin
        dbz_pend    <= 1'b0;
        done        <= 1'b1;
        quotient    <= '1;
        remainder   <= q_work;
        div_by_zero <= 1'b1;
      end
      if (state == CALC) begin
        cnt <= cnt - CW'(1);
        if (last_iter) begin
          done        <= 1'b1;
          quotient    <= {q_work[WIDTH-2:0], q_bit};
          remainder   <= r_step;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  // Working registers carry no reset; they are loaded on every accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_work  <= dividend;
      div_reg <= divisor;
      r_work  <= '0;
    end else if (state == CALC) begin
      q_work <= {q_work[WIDTH-2:0], q_bit};
      r_work <= r_step;
    end
  end

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq: directed vector table, handshake
// corner sequences, and randomized operands against an arithmetic reference.
module tb_div_restoring_seq;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks   = 0;
  int failures = 0;

  div_restoring_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
  endtask

  // Called from the negedge before the accepting posedge; returns on the done negedge.
  task automatic wait_done(output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic z, output int lat, output int bcnt);
    bcnt = 0;
    lat  = -1;
    q    = 'x;
    r    = 'x;
    z    = 1'bx;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = n - 1;
        q   = quotient;
        r   = remainder;
        z   = div_by_zero;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endtask

  vec_t         vecs[$];
  logic [W-1:0] gq, gr, eq, er, prev_q;
  logic         gz, ez;
  int           lat, bcnt, n;

  initial begin
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    vecs.push_back('{32'd100,      32'd7,        32'd14,         32'd2,    1'b0});
    vecs.push_back('{32'd82347156, 32'd9483,     32'd8683,       32'd6267, 1'b0});
    vecs.push_back('{32'd9483,     32'd82347156, 32'd0,          32'd9483, 1'b0});
    vecs.push_back('{32'd5,        32'd0,        32'hFFFFFFFF,   32'd5,    1'b1});
    vecs.push_back('{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,   32'd0,    1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,          32'd0,    1'b0});
    vecs.push_back('{32'd0,        32'd5,        32'd0,          32'd0,    1'b0});
    vecs.push_back('{32'h80000000, 32'd3,        32'h2AAAAAAA,   32'd2,    1'b0});

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(gq, gr, gz, lat, bcnt);
      check($sformatf("vec%0d_quotient", i), gq, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), gr, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), gz, vecs[i].z);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].z ? 1 : W);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].z ? 0 : W);
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), done, 0);
      check($sformatf("vec%0d_hold", i), quotient, vecs[i].q);
    end

    // Start while busy is ignored; outputs hold the prior result mid-operation.
    prev_q = quotient;
    issue(32'd100, 32'd7);
    lat = -1;
    for (n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (n == 10) begin start = 1'b1; dividend = 32'd50; divisor = 32'd5; end
      if (n == 11) start = 1'b0;
      if (n == 20) check("busy_hold_quotient", quotient, prev_q);
      if (done) begin lat = n - 1; break; end
    end
    check("ignore_latency", lat, W);
    check("ignore_quotient", quotient, 14);
    check("ignore_remainder", remainder, 2);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    wait_done(gq, gr, gz, lat, bcnt);
    check("b2b_latency", lat, W);
    check("b2b_quotient", gq, 10);
    check("b2b_remainder", gr, 0);

    // Asynchronous reset mid-operation abandons it with no done pulse.
    issue(32'd100, 32'd7);
    for (n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
    end
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_quotient", quotient, 0);
    check("mid_rst_remainder", remainder, 0);
    check("mid_rst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) break;
    end
    check("post_rst_no_done", done, 0);
    check("post_rst_idle", busy, 0);
    issue(32'd9, 32'd3);
    wait_done(gq, gr, gz, lat, bcnt);
    check("post_rst_quotient", gq, 3);
    check("post_rst_remainder", gr, 0);
    check("post_rst_latency", lat, W);

    // Randomized operands against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      logic [W-1:0] a, b;
      int sel;
      sel = $urandom_range(0, 4);
      a   = (sel == 4) ? $urandom_range(0, 1000) : $urandom;
      case (sel)
        0:       b = '0;
        1:       b = $urandom_range(1, 255);
        2:       b = a + $urandom_range(0, 3);
        default: b = $urandom;
      endcase
      model(a, b, eq, er, ez);
      issue(a, b);
      wait_done(gq, gr, gz, lat, bcnt);
      check($sformatf("rnd%0d_quotient", k), gq, eq);
      check($sformatf("rnd%0d_remainder", k), gr, er);
      check($sformatf("rnd%0d_dbz", k), gz, ez);
      check($sformatf("rnd%0d_latency", k), lat, ez ? 1 : W);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
